spu_local_store: RTL and testbench

//  Local-store responder for the SPU. Serves the MEM-stage quadword load/store

---
 rtl/spu_local_store_pkg.sv | 18 +
 rtl/spu_local_store_if.sv | 36 +++
 rtl/spu_local_store_ls_sram_1rw.sv | 24 ++
 rtl/spu_local_store.sv | 86 ++++++++
 tb/tb_spu_local_store.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/spu_local_store_pkg.sv
// Shared constants and types for the SPU local store.
package spu_local_store_pkg;

  localparam int LS_QW_AW_DEF        = 14;
  localparam int LS_STARVE_LIMIT_DEF = 8;
  localparam int LS_DATA_W           = 128;
  localparam int LS_ADDR_W           = 32;

  // Big-endian bit numbering: bit 0 is the MSB.
  typedef logic [0:LS_DATA_W-1] ls_data_bus128_t;
  typedef logic [0:LS_ADDR_W-1] ls_addr_bus32_t;

  // Width needed to count 0..limit inclusive.
  function automatic int ls_cnt_w(input int limit);
    return (limit < 1) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/spu_local_store_if.sv
// SPU MEM-stage port and DMA port of the local store, bundled.
interface spu_local_store_if import spu_local_store_pkg::*; ();

  logic            spu_req_valid;
  logic            spu_we;
  ls_addr_bus32_t  spu_addr;
  ls_data_bus128_t spu_wdata;
  logic            spu_stall;
  logic            spu_rvalid;
  ls_data_bus128_t spu_rdata;

  logic            dma_req_valid;
  logic            dma_we;
  ls_addr_bus32_t  dma_addr;
  ls_data_bus128_t dma_wdata;
  logic            dma_req_ready;
  logic            dma_rvalid;
  ls_data_bus128_t dma_rdata;

  // Requesters: the SPU pipeline and the DMA engine.
  modport master (
    output spu_req_valid, spu_we, spu_addr, spu_wdata,
    input  spu_stall, spu_rvalid, spu_rdata,
    output dma_req_valid, dma_we, dma_addr, dma_wdata,
    input  dma_req_ready, dma_rvalid, dma_rdata
  );

  // Responder: the local store.
  modport slave (
    input  spu_req_valid, spu_we, spu_addr, spu_wdata,
    output spu_stall, spu_rvalid, spu_rdata,
    input  dma_req_valid, dma_we, dma_addr, dma_wdata,
    output dma_req_ready, dma_rvalid, dma_rdata
  );

endinterface

// File: rtl/spu_local_store_ls_sram_1rw.sv
// Single-port 2^AW x DATA_W array with synchronous read and write enable.
module ls_sram_1rw import spu_local_store_pkg::*; #(
  parameter int LS_QW_AW = LS_QW_AW_DEF,
  parameter int DATA_W   = LS_DATA_W
) (
  input  logic                clk,
  input  logic                en,
  input  logic                we,
  input  logic [LS_QW_AW-1:0] addr,
  input  logic [0:DATA_W-1]   wdata,
  output logic [0:DATA_W-1]   dout
);

  logic [0:DATA_W-1] mem [2**LS_QW_AW];

  // One access per cycle: write updates the array, read registers dout.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[addr] <= wdata;
      else    dout      <= mem[addr];
    end
  end

endmodule

// File: rtl/spu_local_store.sv
// Local store responder: arbitrates SPU (priority) and DMA onto one SRAM,
// with a starvation counter that forces a DMA grant after STARVE_LIMIT refusals.
module spu_local_store import spu_local_store_pkg::*; #(
  parameter int LS_QW_AW     = LS_QW_AW_DEF,
  parameter int STARVE_LIMIT = LS_STARVE_LIMIT_DEF
) (
  input  logic               clk,
  input  logic               rst,
  spu_local_store_if.slave   bus
);

  localparam int DATA_W = LS_DATA_W;
  localparam int CW     = ls_cnt_w(STARVE_LIMIT);
  localparam logic [CW-1:0] LIMIT_C = CW'(STARVE_LIMIT);

  logic [CW-1:0]       starve_cnt;
  logic                grant_dma, grant_spu;
  logic                ram_en, ram_we;
  logic [LS_QW_AW-1:0] ram_addr, spu_idx, dma_idx;
  logic [0:DATA_W-1]   ram_wdata, ram_dout;
  logic                spu_rd_p0, dma_rd_p0;
  logic                spu_vld_p1, dma_vld_p1;
  logic [0:DATA_W-1]   spu_hold_p1, dma_hold_p1;
  logic                unused_addr_bits;

  // Quadword index; byte offset and bits above the store size are dropped.
  assign spu_idx = bus.spu_addr[28-LS_QW_AW:27];
  assign dma_idx = bus.dma_addr[28-LS_QW_AW:27];
  assign unused_addr_bits = ^{bus.spu_addr[0:27-LS_QW_AW], bus.spu_addr[28:31],
                              bus.dma_addr[0:27-LS_QW_AW], bus.dma_addr[28:31]};

  assign grant_dma = bus.dma_req_valid & (~bus.spu_req_valid | (starve_cnt == LIMIT_C));
  assign grant_spu = bus.spu_req_valid & ~grant_dma;

  assign bus.dma_req_ready = grant_dma;
  assign bus.spu_stall     = bus.spu_req_valid & grant_dma;

  // An access on the reset edge is dropped so stores cannot land during reset.
  assign ram_en    = (grant_dma | grant_spu) & ~rst;
  assign ram_we    = grant_dma ? bus.dma_we    : bus.spu_we;
  assign ram_addr  = grant_dma ? dma_idx       : spu_idx;
  assign ram_wdata = grant_dma ? bus.dma_wdata : bus.spu_wdata;

  assign spu_rd_p0 = grant_spu & ~bus.spu_we;
  assign dma_rd_p0 = grant_dma & ~bus.dma_we;

  ls_sram_1rw #(.LS_QW_AW(LS_QW_AW), .DATA_W(DATA_W)) u_sram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .dout  (ram_dout)
  );

  // ---- p0 -> p1: read-valid per port and saturating starvation counter
  always_ff @(posedge clk) begin
    if (rst) begin
      spu_vld_p1 <= 1'b0;
      dma_vld_p1 <= 1'b0;
      starve_cnt <= '0;
    end else begin
      spu_vld_p1 <= spu_rd_p0;
      dma_vld_p1 <= dma_rd_p0;
      if (~bus.dma_req_valid | grant_dma) starve_cnt <= '0;
      else if (starve_cnt != LIMIT_C)     starve_cnt <= starve_cnt + CW'(1);
    end
  end

  // Per-port copy of the last delivered read so rdata holds between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      spu_hold_p1 <= '0;
      dma_hold_p1 <= '0;
    end else begin
      if (spu_vld_p1) spu_hold_p1 <= ram_dout;
      if (dma_vld_p1) dma_hold_p1 <= ram_dout;
    end
  end

  assign bus.spu_rvalid = spu_vld_p1;
  assign bus.dma_rvalid = dma_vld_p1;
  assign bus.spu_rdata  = spu_vld_p1 ? ram_dout : spu_hold_p1;
  assign bus.dma_rdata  = dma_vld_p1 ? ram_dout : dma_hold_p1;

endmodule

// File: tb/tb_spu_local_store.sv
// Directed bench for spu_local_store: reset, store/load, wrap, starvation,
// DMA-to-SPU visibility, reset during read, no write during reset.
module tb_spu_local_store;
  import spu_local_store_pkg::*;

  logic clk = 1'b0;
  logic rst;
  int   n_err = 0;
  int   n_chk = 0;

  spu_local_store_if bus ();

  spu_local_store dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  localparam logic [127:0] D1 = 128'h00112233445566778899AABBCCDDEEFF;
  localparam logic [127:0] D2 = 128'hA5A5A5A5_01234567_89ABCDEF_5A5A5A5A;
  localparam logic [127:0] D3 = 128'hFEEDFACE_CAFEBABE_DEADBEEF_0BADF00D;
  localparam logic [127:0] D4 = 128'h11112222_33334444_55556666_77778888;
  localparam logic [127:0] D5 = 128'hC0C0C0C0_C1C1C1C1_C2C2C2C2_C3C3C3C3;
  localparam logic [127:0] D6 = 128'h99999999_88888888_77777777_66666666;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic spu_drive(input logic v, input logic we, input logic [31:0] a, input logic [127:0] d);
    bus.spu_req_valid = v;
    bus.spu_we        = we;
    bus.spu_addr      = a;
    bus.spu_wdata     = d;
  endtask

  task automatic dma_drive(input logic v, input logic we, input logic [31:0] a, input logic [127:0] d);
    bus.dma_req_valid = v;
    bus.dma_we        = we;
    bus.dma_addr      = a;
    bus.dma_wdata     = d;
  endtask

  initial begin
    rst = 1'b1;
    spu_drive(1'b0, 1'b0, 32'h0, '0);
    dma_drive(1'b0, 1'b0, 32'h0, '0);

    // Reset for two cycles with an SPU request active.
    #1;
    spu_drive(1'b1, 1'b1, 32'h0000_0120, D6);
    tick();
    tick();
    check("rst_spu_rvalid", {127'b0, bus.spu_rvalid}, 128'd0);
    check("rst_dma_rvalid", {127'b0, bus.dma_rvalid}, 128'd0);
    check("rst_spu_rdata", bus.spu_rdata, 128'd0);
    check("rst_dma_rdata", bus.dma_rdata, 128'd0);
    check("rst_starve", 128'(dut.starve_cnt), 128'd0);

    // SPU store then load with different low address bits.
    rst = 1'b0;
    spu_drive(1'b1, 1'b1, 32'h0000_0120, D1);
    #1;
    check("st_stall", {127'b0, bus.spu_stall}, 128'd0);
    tick();
    check("st_no_rvalid", {127'b0, bus.spu_rvalid}, 128'd0);
    spu_drive(1'b1, 1'b0, 32'h0000_012C, '0);
    tick();
    check("ld_rvalid", {127'b0, bus.spu_rvalid}, 128'd1);
    check("ld_rdata", bus.spu_rdata, D1);
    spu_drive(1'b0, 1'b0, 32'h0, '0);
    tick();
    check("ld_pulse", {127'b0, bus.spu_rvalid}, 128'd0);
    check("ld_hold", bus.spu_rdata, D1);

    // Wrap modulo 256 KB.
    spu_drive(1'b1, 1'b1, 32'h0004_0010, D2);
    tick();
    spu_drive(1'b1, 1'b1, 32'h0000_0020, D3);
    tick();
    // Back-to-back loads.
    spu_drive(1'b1, 1'b0, 32'h0000_0010, '0);
    tick();
    check("wrap_rvalid", {127'b0, bus.spu_rvalid}, 128'd1);
    check("wrap_rdata", bus.spu_rdata, D2);
    spu_drive(1'b1, 1'b0, 32'h0000_0020, '0);
    tick();
    check("b2b_rvalid", {127'b0, bus.spu_rvalid}, 128'd1);
    check("b2b_rdata", bus.spu_rdata, D3);

    // Starvation: contention every cycle, DMA forced on the 9th.
    check("starve_start", 128'(dut.starve_cnt), 128'd0);
    spu_drive(1'b1, 1'b0, 32'h0000_0010, '0);
    dma_drive(1'b1, 1'b0, 32'h0000_0120, '0);
    for (int i = 1; i <= 9; i++) begin
      #1;
      check($sformatf("starve_ready_%0d", i), {127'b0, bus.dma_req_ready}, (i == 9) ? 128'd1 : 128'd0);
      check($sformatf("starve_stall_%0d", i), {127'b0, bus.spu_stall}, (i == 9) ? 128'd1 : 128'd0);
      tick();
      check($sformatf("starve_cnt_%0d", i), 128'(dut.starve_cnt), (i == 9) ? 128'd0 : 128'(i));
    end
    check("starve_dma_rvalid", {127'b0, bus.dma_rvalid}, 128'd1);
    check("starve_dma_rdata", bus.dma_rdata, D1);
    check("starve_spu_rvalid", {127'b0, bus.spu_rvalid}, 128'd0);
    spu_drive(1'b0, 1'b0, 32'h0, '0);
    dma_drive(1'b0, 1'b0, 32'h0, '0);
    tick();

    // DMA write with SPU idle, then SPU reads it.
    dma_drive(1'b1, 1'b1, 32'h0000_0400, D4);
    #1;
    check("dmaw_ready", {127'b0, bus.dma_req_ready}, 128'd1);
    tick();
    check("dmaw_no_rvalid", {127'b0, bus.dma_rvalid}, 128'd0);
    dma_drive(1'b0, 1'b0, 32'h0, '0);
    spu_drive(1'b1, 1'b0, 32'h0000_0400, '0);
    tick();
    check("dmaw_spu_rvalid", {127'b0, bus.spu_rvalid}, 128'd1);
    check("dmaw_spu_rdata", bus.spu_rdata, D4);
    check("dmaw_dma_rvalid", {127'b0, bus.dma_rvalid}, 128'd0);

    // Reset on the edge that accepts a load, with starvation built up.
    spu_drive(1'b1, 1'b0, 32'h0000_0120, '0);
    dma_drive(1'b1, 1'b0, 32'h0000_0400, '0);
    tick();
    tick();
    tick();
    check("pre_rst_cnt", 128'(dut.starve_cnt), 128'd3);
    rst = 1'b1;
    tick();
    check("midrd_spu_rvalid", {127'b0, bus.spu_rvalid}, 128'd0);
    check("midrd_dma_rvalid", {127'b0, bus.dma_rvalid}, 128'd0);
    check("midrd_starve", 128'(dut.starve_cnt), 128'd0);
    check("midrd_spu_rdata", bus.spu_rdata, 128'd0);
    dma_drive(1'b0, 1'b0, 32'h0, '0);

    // A store on a reset edge must not land.
    rst = 1'b0;
    spu_drive(1'b1, 1'b1, 32'h0000_0300, D5);
    tick();
    rst = 1'b1;
    spu_drive(1'b1, 1'b1, 32'h0000_0300, D6);
    tick();
    rst = 1'b0;
    spu_drive(1'b1, 1'b0, 32'h0000_0300, '0);
    tick();
    check("rstwr_rvalid", {127'b0, bus.spu_rvalid}, 128'd1);
    check("rstwr_rdata", bus.spu_rdata, D5);
    spu_drive(1'b0, 1'b0, 32'h0, '0);
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
